// File: rtl/video_sync_gen.sv
// Pixel-clock divider, horizontal/vertical timing counters, sync/active generation
// and a small CPU register block with a sticky line-compare interrupt.
module video_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       wren,
  input  logic       ren,
  input  logic [1:0] addr,
  input  logic [7:0] from_cpu,
  output logic [7:0] to_cpu,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pix_ce,
  output logic       line_int
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LIMIT  = 11'(V_TOTAL);

  logic [3:0] div_r;
  logic [9:0] h_count_r;
  logic [9:0] v_count_r;
  logic [9:0] cmp_r;
  logic       enable_r;
  logic       int_en_r;
  logic       line_int_r;
  logic [7:0] to_cpu_r;
  logic       hsync_r;
  logic       vsync_r;
  logic       active_r;
  logic       pix_ce_r;

  logic       wr_s;
  logic       rd_s;
  logic       ctrl_wr_s;
  logic       en_next_s;
  logic       run_s;
  logic       tick_s;
  logic       h_wrap_s;
  logic       line_set_s;
  logic       line_clr_s;
  logic [3:0] div_next_s;
  logic [9:0] h_next_s;
  logic [9:0] v_next_s;
  logic       hsync_next_s;
  logic       vsync_next_s;
  logic       active_next_s;
  logic [7:0] rd_data_s;

  assign wr_s      = ce & wren;
  assign rd_s      = ce & ren;
  assign ctrl_wr_s = wr_s && (addr == 2'd3);
  // A control write takes effect on the same edge, so disabling parks the counters immediately.
  assign en_next_s = ctrl_wr_s ? from_cpu[0] : enable_r;
  assign run_s     = enable_r & en_next_s;
  assign tick_s    = run_s && (div_r == DIV_LAST);
  assign h_wrap_s  = (h_count_r == H_LAST);

  // Next-state divider and pixel/line counters.
  always_comb begin
    div_next_s = div_r;
    h_next_s   = h_count_r;
    v_next_s   = v_count_r;
    if (!en_next_s) begin
      div_next_s = 4'd0;
      h_next_s   = 10'd0;
      v_next_s   = 10'd0;
    end else if (tick_s) begin
      div_next_s = 4'd0;
      if (h_wrap_s) begin
        h_next_s = 10'd0;
        if (v_count_r == V_LAST) begin
          v_next_s = 10'd0;
        end else begin
          v_next_s = v_count_r + 10'd1;
        end
      end else begin
        h_next_s = h_count_r + 10'd1;
      end
    end else if (run_s) begin
      div_next_s = div_r + 4'd1;
    end else begin
      div_next_s = div_r;
    end
  end

  // Sync and visible-area decode from the next-state counters (no output lag).
  always_comb begin
    hsync_next_s  = 1'b1;
    vsync_next_s  = 1'b1;
    active_next_s = 1'b0;
    if (en_next_s) begin
      hsync_next_s  = !((h_next_s >= HS_START) && (h_next_s < HS_END));
      vsync_next_s  = !((v_next_s >= VS_START) && (v_next_s < VS_END));
      active_next_s = (h_next_s < H_VIS) && (v_next_s < V_VIS);
    end else begin
      hsync_next_s  = 1'b1;
      vsync_next_s  = 1'b1;
      active_next_s = 1'b0;
    end
  end

  assign line_set_s = tick_s && h_wrap_s && int_en_r && (v_next_s == cmp_r) &&
                      ({1'b0, cmp_r} < V_LIMIT);
  assign line_clr_s = ctrl_wr_s && from_cpu[7];

  // CPU read multiplexer.
  always_comb begin
    rd_data_s = 8'h00;
    case (addr)
      2'd0:    rd_data_s = v_count_r[7:0];
      2'd1:    rd_data_s = {~hsync_r, ~vsync_r, active_r, line_int_r, 2'b00, v_count_r[9:8]};
      2'd2:    rd_data_s = h_count_r[9:2];
      2'd3:    rd_data_s = {line_int_r, 5'b0_0000, int_en_r, enable_r};
      default: rd_data_s = 8'h00;
    endcase
  end

  // Timing state, registered outputs and CPU registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r      <= 4'd0;
      h_count_r  <= 10'd0;
      v_count_r  <= 10'd0;
      cmp_r      <= 10'd0;
      enable_r   <= 1'b1;
      int_en_r   <= 1'b0;
      line_int_r <= 1'b0;
      to_cpu_r   <= 8'h00;
      hsync_r    <= 1'b1;
      vsync_r    <= 1'b1;
      active_r   <= 1'b1;
      pix_ce_r   <= 1'b0;
    end else begin
      div_r     <= div_next_s;
      h_count_r <= h_next_s;
      v_count_r <= v_next_s;
      hsync_r   <= hsync_next_s;
      vsync_r   <= vsync_next_s;
      active_r  <= active_next_s;
      pix_ce_r  <= tick_s;
      if (wr_s) begin
        case (addr)
          2'd0:    cmp_r[7:0] <= from_cpu;
          2'd1:    cmp_r[9:8] <= from_cpu[1:0];
          2'd3: begin
            enable_r <= from_cpu[0];
            int_en_r <= from_cpu[1];
          end
          default: cmp_r <= cmp_r;
        endcase
      end
      // Set has priority over a coincident clear so no match is ever lost.
      if (line_set_s) begin
        line_int_r <= 1'b1;
      end else if (line_clr_s) begin
        line_int_r <= 1'b0;
      end
      if (rd_s) begin
        to_cpu_r <= rd_data_s;
      end
    end
  end

  assign to_cpu   = to_cpu_r;
  assign hsync    = hsync_r;
  assign vsync    = vsync_r;
  assign active   = active_r;
  assign pixel_x  = h_count_r;
  assign pixel_y  = v_count_r;
  assign pix_ce   = pix_ce_r;
  assign line_int = line_int_r;

endmodule
